// File: rtl/fwd_mux_stage.sv
// fwd_mux_stage: registered N:1 operand-forwarding mux with stall/flush, valid tracking and sticky select-error reporting.
module fwd_mux_stage #(
  parameter int WIDTH = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W = $clog2(NUM_IN),
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    clear_err,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    sel_err,
  output logic [7:0]              err_count
);
  localparam int SLOTS = 2 ** SEL_W;
  localparam bit POW2 = (NUM_IN == SLOTS);
  // Every encodable select has a table entry, so the index is always in range.
  logic [WIDTH-1:0] in_arr [SLOTS];
  for (genvar i = 0; i < SLOTS; i++) begin : g_arr
    if (i < NUM_IN) begin : g_in
      assign in_arr[i] = in_data[i*WIDTH +: WIDTH];
    end else begin : g_def
      assign in_arr[i] = DEFAULT_VAL;
    end
  end
  logic             sel_oob, capture, err_evt;
  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;
  logic [SEL_W-1:0] sel_d, sel_q;
  logic             err_d, err_q;
  logic [7:0]       cnt_d, cnt_q;
  always_comb begin
    sel_oob = !POW2 && ({1'b0, sel} >= (SEL_W+1)'(NUM_IN));
    capture = !flush && !stall;
    err_evt = capture && in_valid && sel_oob;
    data_d  = flush ? DEFAULT_VAL : (capture && in_valid) ? in_arr[sel] : data_q;
    valid_d = flush ? 1'b0 : stall ? valid_q : in_valid;
    sel_d   = capture ? sel : sel_q;
    err_d   = clear_err ? 1'b0 : (err_q | err_evt);
    cnt_d   = clear_err ? 8'd0 : (err_evt && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= DEFAULT_VAL;
      valid_q <= 1'b0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_sel   = sel_q;
  assign sel_err   = err_q;
  assign err_count = cnt_q;
endmodule

// File: doc/fwd_mux_stage.md
Name: fwd_mux_stage

Overview:
- Parametrised, registered N:1 operand-forwarding multiplexer for the pipelined RISC-V datapath.
- Successor to the combinational 3:1 forwarding mux. Adds:
  - configurable width and input count;
  - a one-cycle output register that honours pipeline stall and flush;
  - valid tracking;
  - a defined default value, replacing high-Z, for out-of-range selects, plus sticky error reporting.
- Sits at the EX-stage operand boundary. Its inputs are the register-file value and the EX/MEM/WB forwarded results.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 3, number of data inputs; legal range 2..8.
- SEL_W, $clog2(NUM_IN), select width (derived, not overridden).
- DEFAULT_VAL, 0, value driven for an out-of-range select and at reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*WIDTH  packed inputs; input i is bits [i*WIDTH +: WIDTH].
- sel  input  SEL_W  binary select.
- in_valid  input  1  current operand/select is meaningful.
- stall  input  1  hold the output register.
- flush  input  1  insert a bubble.
- clear_err  input  1  synchronous clear of sel_err and err_count.
- out_data  output  WIDTH  registered selected operand.
- out_valid  output  1  registered valid.
- out_sel  output  SEL_W  registered copy of the select that was captured.
- sel_err  output  1  sticky flag: an out-of-range select was captured.
- err_count  output  8  saturating count of out-of-range captures.

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0:
  - out_data=DEFAULT_VAL, out_valid=0, out_sel=0, sel_err=0, err_count=0.
  - Release is synchronous to the next rising edge of clk; no output changes on the release edge itself.
  - Reset asserted mid-operation clears all state immediately, regardless of stall or flush.
- Latency is 1 cycle: the value presented at edge k appears on out_data after edge k. There is no combinational path from inputs to outputs.
- Per-edge priority is flush > stall > capture:
  - flush=1: out_valid<=0 and out_data<=DEFAULT_VAL; out_sel holds. Applies even when stall=1.
  - flush=0, stall=1: out_data, out_valid and out_sel all hold.
  - flush=0, stall=0 (capture): out_valid<=in_valid and out_sel<=sel.
    - in_valid=1 and sel<NUM_IN: out_data<=input[sel].
    - in_valid=1 and sel>=NUM_IN (only possible when NUM_IN is not a power of 2): out_data<=DEFAULT_VAL, sel_err<=1, err_count increments. The output is never high-Z or X.
    - in_valid=0: out_data holds its previous value, and no error is recorded for any sel value.
- Error logic:
  - err_count saturates at 255 and does not wrap.
  - sel_err stays 1 until clear_err or reset.
  - clear_err=1 clears sel_err and err_count on the edge. If an error capture occurs on the same edge, clear wins: the result is sel_err=0, err_count=0.
  - Errors are counted only on capture edges. Stall and flush edges never count.
- Timing-neutral: sel is decoded with a constant-width index. No latches, and a single always block for the register bank is acceptable.
- When NUM_IN is a power of 2, the error logic is dead and sel_err is constant 0.

Test Plan:
- Reset and basic select: reset, then capture with NUM_IN=3, in_data={C=0x33333333, B=0x22222222, A=0x11111111}, in_valid=1, sel=0,1,2 on consecutive edges -> out_data is 0x11111111, 0x22222222, 0x33333333 one cycle after each, out_valid=1, out_sel tracks sel.
- Stall/flush priority:
  - capture 0xAAAA5555;
  - stall=1 for 3 cycles while inputs change -> out_data stays 0xAAAA5555, out_valid=1;
  - stall=1 and flush=1 together -> out_valid=0, out_data=0.
- Out-of-range select: NUM_IN=3, sel=3, in_valid=1 -> out_data=DEFAULT_VAL, sel_err=1, err_count=1. Same with in_valid=0 -> no change to err_count.
- Saturation and clear:
  - 300 consecutive sel=3 captures -> err_count=255 and stays there;
  - clear_err pulsed on the same edge as a further error -> sel_err=0, err_count=0.
- Asynchronous reset mid-stall: hold out_data=0xDEADBEEF under stall, drop rst_n between clock edges -> outputs are reset immediately, without waiting for a clock edge. After release, the first capture edge loads new data.
- Parameter sweep: WIDTH=64, NUM_IN=8 -> all 8 inputs are selectable with 1-cycle latency, and sel_err never asserts.
